// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: base-op functions, M-extension funct3
// values and the controller state type.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SLL  = 3'd1;
  localparam logic [2:0] OP_SLT  = 3'd2;
  localparam logic [2:0] OP_SLTU = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SRL  = 3'd5;
  localparam logic [2:0] OP_OR   = 3'd6;
  localparam logic [2:0] OP_AND  = 3'd7;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide engine: one shift-add or restoring-subtract step per
// cycle on unsigned magnitudes, with the sign fix-up applied on the result path.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct3,
  output logic            done,
  output logic [XLEN-1:0] result
);

  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opd;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op;
  logic              neg_q;
  logic              neg_r;

  logic              sa, sb;
  logic [XLEN-1:0]   ma, mb;
  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN+1:0]   sub_diff;
  logic [2*XLEN-1:0] acc_nx;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  always_comb begin
    if (funct3[2]) begin
      sa = !funct3[0] & a[XLEN-1];
      sb = !funct3[0] & b[XLEN-1];
    end else begin
      sa = (funct3 != F3_MULHU) & a[XLEN-1];
      sb = !funct3[1] & b[XLEN-1];
    end
    ma = sa ? -a : a;
    mb = sb ? -b : b;
  end

  // Multiply keeps the multiplier in acc's low half; divide keeps the dividend there
  // and grows the partial remainder in the high half.
  always_comb begin
    add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opd & {XLEN{acc[0]}}};
    rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    sub_diff = {1'b0, rem_sh} - {2'b00, opd};
    acc_nx   = {add_sum, acc[XLEN-1:1]};
    if (op[2]) begin
      if (!sub_diff[XLEN+1])
        acc_nx = {sub_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
        acc_nx = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      opd   <= '0;
      cnt   <= '0;
      op    <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start) begin
      acc   <= {{XLEN{1'b0}}, (funct3[2] ? ma : mb)};
      opd   <= funct3[2] ? mb : ma;
      cnt   <= CNT_W'(XLEN);
      op    <= funct3;
      neg_q <= sa ^ sb;
      neg_r <= sa;
    end else if (cnt != '0) begin
      acc <= acc_nx;
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == CNT_W'(1));

  always_comb begin
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op)
      F3_MUL:                        result = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  result = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               result = quo;
      default:                       result = rem;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked execute-stage ALU: single-cycle base ops plus iterative RV M-extension.
// state | meaning
// IDLE  | ready for a new op
// CALC  | engine iterating, one bit per cycle
// FIX   | sign/half selection, result registered
// DONE  | result valid, waiting for out_ready
module seq_alu
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      sel,
  input  logic            m_ext,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] o,
  output logic            zero,
  output logic            busy
);

  localparam int SH_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state, state_nx;
  logic [SH_W-1:0] shamt;
  logic [XLEN-1:0] base_res, special_res, md_result, o_nx;
  logic            div_zero, div_ovf;
  logic            md_start, md_done, o_load;

  assign shamt = b[SH_W-1:0];

  always_comb begin
    base_res = '0;
    case (sel[2:0])
      OP_ADD:  base_res = sel[3] ? a - b : a + b;
      OP_SLL:  base_res = a << shamt;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, a < b};
      OP_XOR:  base_res = a ^ b;
      OP_SRL: begin
        if (sel[3]) base_res = $unsigned($signed(a) >>> shamt);
        else        base_res = a >> shamt;
      end
      OP_OR:   base_res = a | b;
      OP_AND:  base_res = a & b;
      default: base_res = '0;
    endcase
  end

  // Division corner cases resolve immediately and never enter the engine.
  always_comb begin
    div_zero = sel[2] && (b == '0);
    div_ovf  = sel[2] && !sel[0] && (a == XMIN) && (&b);
    if (div_zero) special_res = sel[1] ? a : '1;
    else          special_res = sel[1] ? '0 : XMIN;
  end

  always_comb begin
    state_nx = state;
    md_start = 1'b0;
    o_load   = 1'b0;
    o_nx     = md_result;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (!m_ext) begin
            o_load   = 1'b1;
            o_nx     = base_res;
            state_nx = DONE;
          end else if (div_zero || div_ovf) begin
            o_load   = 1'b1;
            o_nx     = special_res;
            state_nx = DONE;
          end else begin
            md_start = 1'b1;
            state_nx = CALC;
          end
        end
      end
      CALC: if (md_done) state_nx = FIX;
      FIX: begin
        o_load   = 1'b1;
        state_nx = DONE;
      end
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      o     <= '0;
      zero  <= 1'b1;
    end else begin
      state <= state_nx;
      if (o_load) begin
        o    <= o_nx;
        zero <= ~|o_nx;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == CALC) || (state == FIX);

  muldiv_iter #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .a      (a),
    .b      (b),
    .funct3 (sel[2:0]),
    .done   (md_done),
    .result (md_result)
  );

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (XLEN=32): vector table for results and latency,
// plus hand sequences for backpressure and reset during an iterative op.
module tb_seq_alu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  sel;
  logic        m_ext;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] o;
  logic        zero;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic [3:0]  vsel;
    logic        vm;
    logic [31:0] exp_o;
    int          exp_lat;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs[NVEC];

  seq_alu #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .m_ext     (m_ext),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .zero      (zero),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic [3:0] ts,
                        input logic tm, output logic [31:0] ro, output logic rz,
                        output int rlat, output int busy_low);
    @(negedge clk);
    a = ta; b = tb_v; sel = ts; m_ext = tm; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = ~ta; b = 32'h0; sel = 4'hF; m_ext = ~tm;
    rlat = 1;
    busy_low = 0;
    @(negedge clk);
    while (!out_valid && rlat < 100) begin
      if (!busy) busy_low++;
      @(posedge clk);
      rlat++;
      @(negedge clk);
    end
    ro = o;
    rz = zero;
  endtask

  initial begin
    logic [31:0] ro;
    logic        rz;
    int          rlat, blow, seen;

    vecs[0]  = '{32'h7FFFFFFF, 32'h00000001, 4'h0, 1'b0, 32'h80000000, 1};
    vecs[1]  = '{32'h00000005, 32'h00000005, 4'h8, 1'b0, 32'h00000000, 1};
    vecs[2]  = '{32'h00000001, 32'h00000024, 4'h1, 1'b0, 32'h00000010, 1};
    vecs[3]  = '{32'hFFFFFFFF, 32'h00000001, 4'h2, 1'b0, 32'h00000001, 1};
    vecs[4]  = '{32'hFFFFFFFF, 32'h00000001, 4'h3, 1'b0, 32'h00000000, 1};
    vecs[5]  = '{32'hF0F0F0F0, 32'hFF00FF00, 4'h4, 1'b0, 32'h0FF00FF0, 1};
    vecs[6]  = '{32'h80000000, 32'h00000004, 4'h5, 1'b0, 32'h08000000, 1};
    vecs[7]  = '{32'h80000000, 32'h00000004, 4'hD, 1'b0, 32'hF8000000, 1};
    vecs[8]  = '{32'h0000000F, 32'h000000F0, 4'h6, 1'b0, 32'h000000FF, 1};
    vecs[9]  = '{32'h0000000F, 32'h000000FC, 4'h7, 1'b0, 32'h0000000C, 1};
    vecs[10] = '{32'hFFFFFFFF, 32'h00000002, 4'h0, 1'b1, 32'hFFFFFFFE, 34};
    vecs[11] = '{32'hFFFFFFFF, 32'h00000002, 4'h1, 1'b1, 32'hFFFFFFFF, 34};
    vecs[12] = '{32'hFFFFFFFF, 32'h00000002, 4'h2, 1'b1, 32'hFFFFFFFF, 34};
    vecs[13] = '{32'hFFFFFFFF, 32'h00000002, 4'h3, 1'b1, 32'h00000001, 34};
    vecs[14] = '{32'hFFFFFFF9, 32'h00000002, 4'h4, 1'b1, 32'hFFFFFFFD, 34};
    vecs[15] = '{32'hFFFFFFF9, 32'h00000002, 4'h6, 1'b1, 32'hFFFFFFFF, 34};
    vecs[16] = '{32'h00000007, 32'h00000002, 4'h5, 1'b1, 32'h00000003, 34};
    vecs[17] = '{32'h00000007, 32'h00000002, 4'h7, 1'b1, 32'h00000001, 34};
    vecs[18] = '{32'h00000005, 32'h00000000, 4'h4, 1'b1, 32'hFFFFFFFF, 1};
    vecs[19] = '{32'h00000005, 32'h00000000, 4'h7, 1'b1, 32'h00000005, 1};
    vecs[20] = '{32'h80000000, 32'hFFFFFFFF, 4'h4, 1'b1, 32'h80000000, 1};
    vecs[21] = '{32'h80000000, 32'hFFFFFFFF, 4'h6, 1'b1, 32'h00000000, 1};
    vecs[22] = '{32'h80000000, 32'hFFFFFFFF, 4'h5, 1'b1, 32'h00000000, 34};
    vecs[23] = '{32'h00000003, 32'hFFFFFFFB, 4'h0, 1'b1, 32'hFFFFFFF1, 34};
    vecs[24] = '{32'h00000007, 32'hFFFFFFFE, 4'h6, 1'b1, 32'h00000001, 34};
    vecs[25] = '{32'h80000000, 32'h80000000, 4'h1, 1'b1, 32'h40000000, 34};
    vecs[26] = '{32'hFFFFFFFD, 32'h00000000, 4'h6, 1'b1, 32'hFFFFFFFD, 1};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sel = '0; m_ext = 1'b0; out_ready = 1'b0;
    #12;
    chk("reset o", o, 32'h0);
    chk("reset zero", {31'b0, zero}, 32'h1);
    chk("reset out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-reset in_ready", {31'b0, in_ready}, 32'h1);

    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vsel, vecs[i].vm, ro, rz, rlat, blow);
      chk($sformatf("vec%0d o", i), ro, vecs[i].exp_o);
      chk($sformatf("vec%0d zero", i), {31'b0, rz}, {31'b0, vecs[i].exp_o == 32'h0});
      chk($sformatf("vec%0d latency", i), 32'(rlat), 32'(vecs[i].exp_lat));
      if (vecs[i].exp_lat > 1)
        chk($sformatf("vec%0d busy low cycles", i), 32'(blow), 32'h0);
    end

    // Backpressure: result must hold while out_ready is low; new inputs ignored.
    @(negedge clk);
    a = 32'd5; b = 32'd5; sel = 4'h8; m_ext = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    a = 32'h1234; b = 32'h1; sel = 4'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("hold%0d out_valid", i), {31'b0, out_valid}, 32'h1);
      chk($sformatf("hold%0d o", i), o, 32'h0);
      chk($sformatf("hold%0d zero", i), {31'b0, zero}, 32'h1);
      chk($sformatf("hold%0d in_ready", i), {31'b0, in_ready}, 32'h0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release out_valid", {31'b0, out_valid}, 32'h0);
    chk("release in_ready", {31'b0, in_ready}, 32'h1);
    chk("release o", o, 32'h0);

    // Reset while a divide is iterating.
    run_op(32'd1, 32'd2, 4'h0, 1'b0, ro, rz, rlat, blow);
    chk("pre-reset add o", ro, 32'h3);
    @(negedge clk);
    a = 32'd100; b = 32'd3; sel = 4'h4; m_ext = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("mid-div busy", {31'b0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid reset out_valid", {31'b0, out_valid}, 32'h0);
    chk("mid reset busy", {31'b0, busy}, 32'h0);
    chk("mid reset o", o, 32'h0);
    chk("mid reset zero", {31'b0, zero}, 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("after reset in_ready", {31'b0, in_ready}, 32'h1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    chk("no stale result", 32'(seen), 32'h0);
    run_op(32'd2, 32'd3, 4'h0, 1'b0, ro, rz, rlat, blow);
    chk("post-reset add o", ro, 32'h5);
    chk("post-reset add latency", 32'(rlat), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
